axil_reg_access_arbiter: RTL and testbench

- Shares one AXI4-Lite master port between two register-access requesters. Typical requesters are game logic and a PS-side command path; the slave is the 4-register LED matrix control IP.
- Grants requesters round-robin, runs one AXI4-Lite read or write per grant, and returns read data and response to the granted requester.
- Sits between the fabric requesters and the AXI4-Lite slave register block in the block design.

---
 rtl/axil_reg_access_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_axil_reg_access_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_access_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master port between two
// register-access requesters, one transaction in flight at a time.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | arbitrate between requesters, latch the granted request
// WR_ADDR | AWVALID/WVALID out, each drops after its own handshake
// WR_RESP | BREADY high, waiting for the write response
// RD_ADDR | ARVALID out, waiting for ARREADY
// RD_DATA | RREADY high, waiting for read data
// DONE    | one-cycle req_done pulse to the granted requester
module axil_reg_access_arbiter #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [1:0]                        req_valid,
  input  logic [1:0]                        req_we,
  input  logic [2*C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*C_M_AXI_DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                        req_done,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     req_rdata,
  output logic [1:0]                        req_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t          state, state_n;
  logic            last_grant, last_grant_n;
  logic            grant, grant_n;
  logic            awvalid, awvalid_n;
  logic            wvalid, wvalid_n;
  logic            bready, bready_n;
  logic            arvalid, arvalid_n;
  logic            rready, rready_n;
  logic [AW-1:0]   addr, addr_n;
  logic [DW-1:0]   wdata, wdata_n;
  logic [DW-1:0]   rdata, rdata_n;
  logic [1:0]      resp, resp_n;
  logic [1:0]      done, done_n;

  logic            sel;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic            aw_hs, w_hs;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      rdata      <= '0;
      resp       <= '0;
      done       <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      grant      <= grant_n;
      awvalid    <= awvalid_n;
      wvalid     <= wvalid_n;
      bready     <= bready_n;
      arvalid    <= arvalid_n;
      rready     <= rready_n;
      addr       <= addr_n;
      wdata      <= wdata_n;
      rdata      <= rdata_n;
      resp       <= resp_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    grant_n      = grant;
    awvalid_n    = awvalid;
    wvalid_n     = wvalid;
    bready_n     = bready;
    arvalid_n    = arvalid;
    rready_n     = rready;
    addr_n       = addr;
    wdata_n      = wdata;
    rdata_n      = rdata;
    resp_n       = resp;
    done_n       = '0;

    // On a tie the requester that did not win last time gets the port.
    sel       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    sel_we    = sel ? req_we[1] : req_we[0];
    sel_addr  = sel ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    sel_wdata = sel ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
    aw_hs     = awvalid & M_AXI_AWREADY;
    w_hs      = wvalid & M_AXI_WREADY;

    case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          grant_n      = sel;
          last_grant_n = sel;
          addr_n       = {sel_addr[AW-1:2], 2'b00};
          wdata_n      = sel_wdata;
          if (sel_we) begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = WR_ADDR;
          end else begin
            arvalid_n = 1'b1;
            state_n   = RD_ADDR;
          end
        end
      end
      WR_ADDR: begin
        if (aw_hs) awvalid_n = 1'b0;
        if (w_hs)  wvalid_n  = 1'b0;
        // A dropped VALID means that channel already handshook earlier.
        if ((!awvalid || aw_hs) && (!wvalid || w_hs)) begin
          bready_n = 1'b1;
          state_n  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (bready && M_AXI_BVALID) begin
          resp_n   = M_AXI_BRESP;
          bready_n = 1'b0;
          done_n   = grant ? 2'b10 : 2'b01;
          state_n  = DONE;
        end
      end
      RD_ADDR: begin
        if (arvalid && M_AXI_ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rready && M_AXI_RVALID) begin
          rdata_n  = M_AXI_RDATA;
          resp_n   = M_AXI_RRESP;
          rready_n = 1'b0;
          done_n   = grant ? 2'b10 : 2'b01;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign req_done      = done;
  assign req_rdata     = rdata;
  assign req_resp      = resp;
  assign M_AXI_AWADDR  = addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_WDATA   = wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = bready;
  assign M_AXI_ARADDR  = addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid;
  assign M_AXI_RREADY  = rready;

endmodule

// File: tb/tb_axil_reg_access_arbiter.sv
// Bench for axil_reg_access_arbiter: 4-register AXI4-Lite slave model with
// programmable stalls, and a scoreboard of expected req_done responses.
module tb_axil_reg_access_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [1:0]  req_valid, req_we;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_done;
  logic [31:0] req_rdata;
  logic [1:0]  req_resp;
  logic [3:0]  M_AXI_AWADDR, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [31:0] M_AXI_WDATA, M_AXI_RDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  axil_reg_access_arbiter #(.C_M_AXI_ADDR_WIDTH(4), .C_M_AXI_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: stall counts per channel, registers reset with ARESET.
  logic [3:0]  aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
  logic [1:0]  bresp_cfg = 0, rresp_cfg = 0;
  logic        rd_override = 0;
  logic [31:0] override_val = 0;
  logic [3:0]  aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt;
  logic        s_aw_got, s_w_got, b_pend, r_pend;
  logic [3:0]  s_aw_addr, s_ar_addr;
  logic [31:0] s_wdata;
  logic [31:0] mem [4];
  logic        aw_hs, w_hs, ar_hs;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_delay);
  assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_delay);
  assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_delay);
  assign M_AXI_BVALID  = b_pend && (b_cnt >= b_delay);
  assign M_AXI_RVALID  = r_pend && (r_cnt >= r_delay);
  assign M_AXI_BRESP   = bresp_cfg;
  assign M_AXI_RRESP   = rresp_cfg;
  assign M_AXI_RDATA   = rd_override ? override_val : mem[s_ar_addr[3:2]];
  assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID && M_AXI_WREADY;
  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; b_cnt <= 0;
      s_aw_got <= 0; s_w_got <= 0; b_pend <= 0; r_pend <= 0;
      s_aw_addr <= 0; s_ar_addr <= 0; s_wdata <= 0;
      for (int i = 0; i < 4; i++) mem[i] <= 0;
    end else begin
      aw_cnt <= (M_AXI_AWVALID && !aw_hs) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_AXI_WVALID && !w_hs) ? w_cnt + 1 : 0;
      ar_cnt <= (M_AXI_ARVALID && !ar_hs) ? ar_cnt + 1 : 0;
      if (aw_hs) begin s_aw_got <= 1; s_aw_addr <= M_AXI_AWADDR; end
      if (w_hs)  begin s_w_got <= 1; s_wdata <= M_AXI_WDATA; end
      if ((s_aw_got || aw_hs) && (s_w_got || w_hs) && !b_pend) begin
        b_pend   <= 1;
        s_aw_got <= 0;
        s_w_got  <= 0;
        mem[aw_hs ? M_AXI_AWADDR[3:2] : s_aw_addr[3:2]] <= w_hs ? M_AXI_WDATA : s_wdata;
      end
      if (b_pend && !M_AXI_BVALID) b_cnt <= b_cnt + 1;
      if (M_AXI_BVALID && M_AXI_BREADY) begin b_pend <= 0; b_cnt <= 0; end
      if (ar_hs) begin r_pend <= 1; s_ar_addr <= M_AXI_ARADDR; end
      if (r_pend && !M_AXI_RVALID) r_cnt <= r_cnt + 1;
      if (M_AXI_RVALID && M_AXI_RREADY) begin r_pend <= 0; r_cnt <= 0; end
    end
  end

  typedef struct {
    logic [1:0]  done;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] exp_last = 0;

  task automatic push_exp(input int idx, input logic [31:0] rd, input logic [1:0] resp);
    exp_t e;
    e.done  = (idx == 1) ? 2'b10 : 2'b01;
    e.rdata = rd;
    e.resp  = resp;
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard on req_done plus AXI protocol checks.
  int   mon_aw_n = 0, mon_w_n = 0;
  logic prev_arvalid = 0, prev_arready = 0, prev_awvalid = 0, prev_awready = 0;
  logic prev_wvalid = 0, prev_wready = 0;
  logic [3:0]  prev_araddr = 0, prev_awaddr = 0;
  logic [31:0] prev_wdata = 0;

  always @(negedge ACLK) begin
    exp_t e;
    if (req_done != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {30'd0, req_done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_idx", {30'd0, req_done}, {30'd0, e.done});
        chk("rdata", req_rdata, e.rdata);
        chk("resp", {30'd0, req_resp}, {30'd0, e.resp});
      end
    end
    if (!ARESET) begin
      if (M_AXI_ARVALID) chk("ar_excl_aw_w", {31'd0, M_AXI_AWVALID | M_AXI_WVALID}, 32'd0);
      if (aw_hs) begin mon_aw_n++; chk("awaddr_align", {30'd0, M_AXI_AWADDR[1:0]}, 32'd0); end
      if (w_hs)  mon_w_n++;
      if (ar_hs) chk("araddr_align", {30'd0, M_AXI_ARADDR[1:0]}, 32'd0);
      if (M_AXI_BREADY) chk("bready_after_aw_w", {31'd0, mon_aw_n == 1 && mon_w_n == 1}, 32'd1);
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        chk("aw_hs_count", mon_aw_n, 1);
        chk("w_hs_count", mon_w_n, 1);
        mon_aw_n = 0;
        mon_w_n  = 0;
      end
      if (prev_arvalid && !prev_arready) begin
        chk("arvalid_held", {31'd0, M_AXI_ARVALID}, 32'd1);
        chk("araddr_stable", {28'd0, M_AXI_ARADDR}, {28'd0, prev_araddr});
      end
      if (prev_awvalid && !prev_awready) begin
        chk("awvalid_held", {31'd0, M_AXI_AWVALID}, 32'd1);
        chk("awaddr_stable", {28'd0, M_AXI_AWADDR}, {28'd0, prev_awaddr});
      end
      if (prev_wvalid && !prev_wready) begin
        chk("wvalid_held", {31'd0, M_AXI_WVALID}, 32'd1);
        chk("wdata_stable", M_AXI_WDATA, prev_wdata);
      end
    end else begin
      mon_aw_n = 0;
      mon_w_n  = 0;
    end
    prev_arvalid = M_AXI_ARVALID; prev_arready = M_AXI_ARREADY; prev_araddr = M_AXI_ARADDR;
    prev_awvalid = M_AXI_AWVALID; prev_awready = M_AXI_AWREADY; prev_awaddr = M_AXI_AWADDR;
    prev_wvalid  = M_AXI_WVALID;  prev_wready  = M_AXI_WREADY;  prev_wdata  = M_AXI_WDATA;
  end

  // One access from requester idx; payload is scrambled after grant.
  task automatic do_access(input int idx, input bit we, input logic [3:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input logic [1:0] resp, input bit lat_chk);
    int cyc;
    bit seen;
    @(posedge ACLK); #1;
    req_we[idx] = we;
    req_addr[idx*4 +: 4] = addr;
    req_wdata[idx*32 +: 32] = wd;
    if (!we) exp_last = rd;
    push_exp(idx, exp_last, resp);
    req_valid[idx] = 1'b1;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge ACLK);
      if (req_done[idx]) seen = 1;
      else begin
        @(posedge ACLK); #1;
        cyc++;
        if (cyc == 1) begin
          req_addr[idx*4 +: 4] = ~addr;
          req_wdata[idx*32 +: 32] = ~wd;
          req_we[idx] = ~we;
        end
      end
    end
    req_valid[idx] = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (lat_chk) chk("latency", cyc, 3);
  endtask

  initial begin
    int ndone;
    bit seen;
    ARESET    = 1;
    req_we    = 2'b01;
    req_addr  = {4'h4, 4'h4};
    req_wdata = {32'h0, 32'h11};
    req_valid = 2'b11;
    // Contention: req0 writes 0x11 to 0x4, req1 reads 0x4, alternating.
    for (int i = 0; i < 3; i++) begin
      push_exp(0, (i == 0) ? 32'h0 : 32'h11, 2'b00);
      push_exp(1, 32'h11, 2'b00);
    end
    repeat (3) @(posedge ACLK);
    #1 ARESET = 0;
    chk("reset_done", {30'd0, req_done}, 32'd0);
    chk("reset_rdata", req_rdata, 32'd0);
    chk("reset_valids", {27'd0, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 200 && ndone < 6; c++) begin
      @(negedge ACLK);
      if (req_done != 2'b00) begin
        ndone++;
        if (ndone == 6) req_valid = 2'b00;
      end
    end
    chk("contention_count", ndone, 6);
    exp_last = 32'h11;

    // Single requester sequence, zero-wait slave.
    do_access(0, 1, 4'h0, 32'h1, 0, 2'b00, 1);
    do_access(0, 1, 4'h4, 32'h2, 0, 2'b00, 1);
    do_access(0, 1, 4'h8, 32'h3, 0, 2'b00, 1);
    do_access(0, 1, 4'hC, 32'h4, 0, 2'b00, 1);
    do_access(0, 0, 4'h0, 0, 32'h1, 2'b00, 1);
    do_access(0, 0, 4'h4, 0, 32'h2, 2'b00, 1);
    do_access(0, 0, 4'h8, 0, 32'h3, 2'b00, 1);
    do_access(0, 0, 4'hC, 0, 32'h4, 2'b00, 1);

    // Channel skew in both directions, then an unaligned read-back.
    aw_delay = 3; w_delay = 0;
    do_access(1, 1, 4'h8, 32'h55, 0, 2'b00, 0);
    aw_delay = 0; w_delay = 3;
    do_access(0, 1, 4'hC, 32'h66, 0, 2'b00, 0);
    w_delay = 0;
    do_access(1, 0, 4'hB, 0, 32'h55, 2'b00, 1);
    do_access(0, 0, 4'hD, 0, 32'h66, 2'b00, 1);

    // Read backpressure.
    ar_delay = 5; r_delay = 4; rd_override = 1; override_val = 32'hDEADBEEF;
    do_access(0, 0, 4'h0, 0, 32'hDEADBEEF, 2'b00, 0);
    ar_delay = 0; r_delay = 0; rd_override = 0;

    // Error pass-through.
    bresp_cfg = 2'b10;
    do_access(0, 1, 4'h0, 32'h77, 0, 2'b10, 1);
    bresp_cfg = 2'b00; rresp_cfg = 2'b11;
    do_access(1, 0, 4'h6, 0, 32'h2, 2'b11, 1);
    rresp_cfg = 2'b00;

    // Reset while waiting in WR_RESP.
    b_delay = 5;
    @(posedge ACLK); #1;
    req_we = 2'b10; req_addr = 8'h00; req_wdata = {32'h99, 32'h0};
    req_valid = 2'b10;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge ACLK);
      if (M_AXI_BREADY) seen = 1;
    end
    chk("reached_wr_resp", {31'd0, seen}, 32'd1);
    @(posedge ACLK); #1 ARESET = 1;
    req_we = 2'b00;
    req_valid = 2'b11;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("rst_bready", {31'd0, M_AXI_BREADY}, 32'd0);
    chk("rst_no_done", {30'd0, req_done}, 32'd0);
    b_delay = 0;
    exp_last = 32'h0;
    push_exp(0, 32'h0, 2'b00);
    @(posedge ACLK); #1 ARESET = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge ACLK);
      if (req_done != 2'b00) begin
        seen = 1;
        req_valid = 2'b00;
      end
    end
    chk("post_rst_done", {31'd0, seen}, 32'd1);

    repeat (6) @(posedge ACLK);
    @(negedge ACLK);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
